// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap sequencer. Arbitrates exceptions, level
//            machine interrupts and mret, then runs FLUSH -> SAVE -> REDIRECT
//            (trap) or FLUSH -> REDIRECT (mret). Computes the mtvec vectored
//            target for interrupts.
// Options  : TRAP_CTRL_WFI_EN adds wfi_valid_i and a WFI wait state.
// Revision : 1.0 - initial release
// ============================================================================

package core_pkg;
    localparam int XLEN = 32;
endpackage

module trap_ctrl
    import core_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            expt_valid_i,
    output logic            expt_ready_o,
    input  logic [4:0]      expt_cause_i,
    input  logic [XLEN-1:0] expt_pc_i,
    input  logic [XLEN-1:0] expt_tval_i,
    input  logic            mret_valid_i,
`ifdef TRAP_CTRL_WFI_EN
    input  logic            wfi_valid_i,
`endif
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic            irq_msw_i,
    input  logic            irq_mtimer_i,
    input  logic            irq_mext_i,
    input  logic            mstatus_mie_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            flush_o,
    output logic            csr_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            mstatus_trap_o,
    output logic            mstatus_mret_o,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_FLUSH    = 3'd1;
    localparam logic [2:0] c_ST_SAVE     = 3'd2;
    localparam logic [2:0] c_ST_REDIRECT = 3'd3;
`ifdef TRAP_CTRL_WFI_EN
    localparam logic [2:0] c_ST_WFI      = 3'd4;
`endif

    localparam logic [4:0] c_CODE_MSI = 5'd3;
    localparam logic [4:0] c_CODE_MTI = 5'd7;
    localparam logic [4:0] c_CODE_MEI = 5'd11;

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [4:0]      r_code;
    logic            r_is_irq;
    logic            r_is_mret;

    // Raw irq vector ordered {MEI, MTI, MSI}
    logic [2:0] w_irq_raw;
    logic [2:0] w_irq_sync;
    assign w_irq_raw = {irq_mext_i, irq_mtimer_i, irq_msw_i};

    generate
        if (IRQ_SYNC_STAGES > 0) begin : g_sync
            logic [2:0] r_sync [IRQ_SYNC_STAGES];
            // Shift each irq level through the synchronizer chain
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < IRQ_SYNC_STAGES; i++) begin
                        r_sync[i] <= '0;
                    end
                end else begin
                    r_sync[0] <= w_irq_raw;
                    for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_irq_sync = r_sync[IRQ_SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_irq_sync = w_irq_raw;
        end
    endgenerate

    logic [2:0] w_pending;
    logic       w_any_pending;
    logic       w_irq_take;
    logic [4:0] w_irq_code;
    assign w_pending     = w_irq_sync & {mie_i[11], mie_i[7], mie_i[3]};
    assign w_any_pending = |w_pending;
    assign w_irq_take    = mstatus_mie_i & w_any_pending & commit_valid_i;

    // Fixed source priority: MEI, then MSI, then MTI
    always_comb begin
        w_irq_code = c_CODE_MTI;
        if (w_pending[2]) begin
            w_irq_code = c_CODE_MEI;
        end else if (w_pending[0]) begin
            w_irq_code = c_CODE_MSI;
        end
    end

    // Trap target: vectored mode adds 4*code for interrupts only
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_target;
    assign w_base        = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_trap_target = (mtvec_i[1:0] == 2'b01 && r_is_irq)
                         ? w_base + {{(XLEN-7){1'b0}}, r_code, 2'b00}
                         : w_base;

    logic [XLEN-1:0] w_irq_cause;
    assign w_irq_cause = {1'b1, {(XLEN-6){1'b0}}, w_irq_code};

    assign expt_ready_o = (r_state == c_ST_IDLE);
    assign busy_o       = (r_state != c_ST_IDLE);

    // Sequencer with registered outputs; single-cycle pulses default to 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= c_ST_IDLE;
            r_epc            <= '0;
            r_cause          <= '0;
            r_tval           <= '0;
            r_code           <= '0;
            r_is_irq         <= 1'b0;
            r_is_mret        <= 1'b0;
            flush_o          <= 1'b0;
            csr_we_o         <= 1'b0;
            mstatus_trap_o   <= 1'b0;
            mstatus_mret_o   <= 1'b0;
            mepc_o           <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            flush_o        <= 1'b0;
            csr_we_o       <= 1'b0;
            mstatus_trap_o <= 1'b0;
            mstatus_mret_o <= 1'b0;
            mepc_o         <= '0;
            mcause_o       <= '0;
            mtval_o        <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (expt_valid_i) begin
                        r_epc     <= expt_pc_i;
                        r_cause   <= {{(XLEN-5){1'b0}}, expt_cause_i};
                        r_tval    <= expt_tval_i;
                        r_code    <= expt_cause_i;
                        r_is_irq  <= 1'b0;
                        r_is_mret <= 1'b0;
                        flush_o   <= 1'b1;
                        r_state   <= c_ST_FLUSH;
                    end else if (w_irq_take) begin
                        r_epc     <= commit_pc_i;
                        r_cause   <= w_irq_cause;
                        r_tval    <= '0;
                        r_code    <= w_irq_code;
                        r_is_irq  <= 1'b1;
                        r_is_mret <= 1'b0;
                        flush_o   <= 1'b1;
                        r_state   <= c_ST_FLUSH;
                    end else if (mret_valid_i) begin
                        r_is_irq       <= 1'b0;
                        r_is_mret      <= 1'b1;
                        flush_o        <= 1'b1;
                        mstatus_mret_o <= 1'b1;
                        r_state        <= c_ST_FLUSH;
                    end
`ifdef TRAP_CTRL_WFI_EN
                    else if (wfi_valid_i) begin
                        r_state <= c_ST_WFI;
                    end
`endif
                end
                c_ST_FLUSH: begin
                    if (r_is_mret) begin
                        redirect_pc_o    <= {mepc_i[XLEN-1:1], 1'b0};
                        redirect_valid_o <= 1'b1;
                        r_state          <= c_ST_REDIRECT;
                    end else begin
                        csr_we_o       <= 1'b1;
                        mstatus_trap_o <= 1'b1;
                        mepc_o         <= {r_epc[XLEN-1:1], 1'b0};
                        mcause_o       <= r_cause;
                        mtval_o        <= r_tval;
                        r_state        <= c_ST_SAVE;
                    end
                end
                c_ST_SAVE: begin
                    redirect_pc_o    <= w_trap_target;
                    redirect_valid_o <= 1'b1;
                    r_state          <= c_ST_REDIRECT;
                end
                c_ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        redirect_pc_o    <= '0;
                        r_state          <= c_ST_IDLE;
                    end
                end
`ifdef TRAP_CTRL_WFI_EN
                c_ST_WFI: begin
                    // Wake ignores the global enable; the trap itself does not
                    if (w_any_pending) begin
                        if (mstatus_mie_i) begin
                            r_epc     <= commit_pc_i;
                            r_cause   <= w_irq_cause;
                            r_tval    <= '0;
                            r_code    <= w_irq_code;
                            r_is_irq  <= 1'b1;
                            r_is_mret <= 1'b0;
                            flush_o   <= 1'b1;
                            r_state   <= c_ST_FLUSH;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Bits that are architecturally ignored here
    logic w_unused;
    assign w_unused = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                        mepc_i[0], r_epc[0]};

endmodule

`default_nettype wire
